key_debounce_array: RTL

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_array.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_array.sv
// Per-key debouncer with press/release/long-press pulses, auto-repeat and a shared any-press strobe.
// Each channel is a two-flop synchronizer feeding an independent 4-state FSM.
`timescale 1ns/1ps

module key_debounce_array #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_flag,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_state,
    output logic              key_any
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W  = $clog2(LONG_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [N_KEYS-1:0] IDLE_LVL  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_MAX - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync_p0;
    logic [N_KEYS-1:0] sync_p1;
    logic [N_KEYS-1:0] s_lvl;

    // Stage p0/p1: two-flop synchronizer, resetting to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

    // XOR with the idle level yields an active-high pressed indication
    assign s_lvl = sync_p1 ^ IDLE_LVL;

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_ch
            state_t             state;
            logic [DEB_W-1:0]   deb_cnt;
            logic [HOLD_W-1:0]  hold_cnt;
            logic [REP_W-1:0]   rep_cnt;
            logic [HOLD_W-1:0]  hold_nxt;
            logic [REP_W-1:0]   rep_nxt;
            logic               long_hit;
            logic               flag_r;
            logic               rel_r;
            logic               long_r;
            logic               lvl_r;
            logic               s;

            assign s = s_lvl[g];

            // Hold counter saturates at the long threshold; repeat phase runs from there
            always_comb begin
                hold_nxt = hold_cnt;
                rep_nxt  = rep_cnt;
                long_hit = 1'b0;
                if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                    rep_nxt  = '0;
                    long_hit = (hold_nxt == HOLD_MAX);
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_nxt  = '0;
                        long_hit = 1'b1;
                    end else begin
                        rep_nxt = rep_cnt + REP_W'(1);
                    end
                end
            end

            // Stage p2: per-channel FSM with registered pulses
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state    <= IDLE;
                    deb_cnt  <= '0;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    flag_r   <= 1'b0;
                    rel_r    <= 1'b0;
                    long_r   <= 1'b0;
                    lvl_r    <= 1'b0;
                end else begin
                    flag_r <= 1'b0;
                    rel_r  <= 1'b0;
                    long_r <= 1'b0;
                    case (state)
                        IDLE: begin
                            if (s) begin
                                state   <= PRESS_WAIT;
                                deb_cnt <= DEB_W'(1);
                            end
                        end
                        PRESS_WAIT: begin
                            if (deb_cnt == DEB_MAX) begin
                                state    <= PRESSED;
                                deb_cnt  <= '0;
                                hold_cnt <= '0;
                                rep_cnt  <= '0;
                                flag_r   <= 1'b1;
                                lvl_r    <= 1'b1;
                            end else if (s) begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end else begin
                                state   <= IDLE;
                                deb_cnt <= '0;
                            end
                        end
                        PRESSED: begin
                            hold_cnt <= hold_nxt;
                            rep_cnt  <= rep_nxt;
                            long_r   <= long_hit;
                            if (!s) begin
                                state   <= RELEASE_WAIT;
                                deb_cnt <= DEB_W'(1);
                            end
                        end
                        RELEASE_WAIT: begin
                            if (deb_cnt == DEB_MAX) begin
                                state   <= IDLE;
                                deb_cnt <= '0;
                                rel_r   <= 1'b1;
                                lvl_r   <= 1'b0;
                            end else begin
                                // Hold time keeps running through a release glitch
                                hold_cnt <= hold_nxt;
                                rep_cnt  <= rep_nxt;
                                long_r   <= long_hit;
                                if (s) begin
                                    state   <= PRESSED;
                                    deb_cnt <= '0;
                                end else begin
                                    deb_cnt <= deb_cnt + DEB_W'(1);
                                end
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end
                    endcase
                end
            end

            assign key_flag[g]    = flag_r;
            assign key_release[g] = rel_r;
            assign key_long[g]    = long_r;
            assign key_state[g]   = lvl_r;
        end
    endgenerate

    // Stage p3: any-press strobe trails the per-key flags by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_any <= 1'b0;
        end else begin
            key_any <= |key_flag;
        end
    end

endmodule
